// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, receiver state encoding and vote helper
package uart_pkg;

  localparam int CLKS_PER_BIT_115200_12MHZ = 104;
  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - rxd synchroniser chain, resets to the idle (high) line level
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rxd_i,
  output logic rxd_s_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], rxd_i};
    end
  end

  assign rxd_s_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 receiver with 3-sample majority vote around each bit centre
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200_12MHZ,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int H     = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(H);
  localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(H + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_e              state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [2:0]             bit_idx_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   rx_byte_q;
  logic                   rx_valid_q;
  logic                   rx_frame_err_q;
  logic                   s0_q;
  logic                   s1_q;

  logic rxd_s;
  logic vote_d;
  logic decide;
  logic cnt_last;

  uart_rx_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .rxd_i   (rxd),
    .rxd_s_o (rxd_s)
  );

  // The third sample is the live synchronised line on the decision edge.
  assign vote_d   = maj3(s0_q, s1_q, rxd_s);
  assign decide   = (cnt_q == CNT_DEC);
  assign cnt_last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      rx_byte_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
      s0_q           <= 1'b1;
      s1_q           <= 1'b1;
    end else begin
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q     <= '0;
          bit_idx_q <= '0;
          if (!rxd_s) begin
            state_q <= START;
          end
        end
        START, DATA, STOP: begin
          cnt_q <= cnt_last ? '0 : cnt_q + CNT_W'(1);
          if (cnt_q == CNT_S0) s0_q <= rxd_s;
          if (cnt_q == CNT_S1) s1_q <= rxd_s;
          case (state_q)
            START: begin
              if (decide && vote_d) begin
                state_q <= IDLE;
              end else if (cnt_last) begin
                state_q   <= DATA;
                bit_idx_q <= '0;
              end
            end
            DATA: begin
              if (decide) shift_q <= {vote_d, shift_q[DATA_BITS-1:1]};
              if (cnt_last) begin
                bit_idx_q <= bit_idx_q + 3'd1;
                if (bit_idx_q == LAST_BIT) state_q <= STOP;
              end
            end
            default: begin
              // Leave at the stop-bit centre so a following start bit is not missed.
              if (decide) begin
                cnt_q <= '0;
                if (vote_d) begin
                  rx_byte_q  <= shift_q;
                  rx_valid_q <= 1'b1;
                  state_q    <= IDLE;
                end else begin
                  rx_frame_err_q <= 1'b1;
                  state_q        <= WAIT_IDLE;
                end
              end
            end
          endcase
        end
        WAIT_IDLE: begin
          cnt_q <= '0;
          if (rxd_s) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign rx_byte      = rx_byte_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized frame stimulus against a frame-level receive model
module tb_uart_rx;

  localparam int BIT = 104;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t_fall = 0;

  typedef struct {
    bit         err;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  int         valid_cyc[$];
  logic [7:0] model_byte = 8'h00;
  ev_t        ev;

  uart_rx dut (
    .clk          (clk),
    .rst          (rst),
    .rxd          (rxd),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v, input int n);
    rxd = v;
    repeat (n) @(negedge clk);
  endtask

  // Drives start, 8 data bits LSB first, stop; optional one-cycle spike in data bit gbit.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int gbit, input int gpos);
    logic [9:0] f;
    ev_t e;
    f = {stop_ok, b, 1'b0};
    e.err = !stop_ok;
    e.data = b;
    exp_q.push_back(e);
    t_fall = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      if (gbit >= 0 && i == gbit + 1) begin
        drive_bit(f[i], gpos);
        drive_bit(~f[i], 1);
        drive_bit(f[i], BIT - gpos - 1);
      end else begin
        drive_bit(f[i], BIT);
      end
    end
  endtask

  // Frame-level model: each strobe must match the next queued frame outcome.
  always @(negedge clk) begin
    if (!rst && (rx_valid || rx_frame_err)) begin
      check("valid_err_exclusive", 32'(rx_valid & rx_frame_err), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {30'd0, rx_valid, rx_frame_err}, 32'd0);
      end else begin
        ev = exp_q.pop_front();
        check("strobe_kind_err", 32'(rx_frame_err), 32'(ev.err));
        if (rx_valid) begin
          check("rx_byte", 32'(rx_byte), 32'(ev.data));
          model_byte = ev.data;
          valid_cyc.push_back(cyc);
        end else begin
          check("rx_byte_held", 32'(rx_byte), 32'(model_byte));
        end
      end
    end
  end

  initial begin
    int n0;
    int busy_cnt;
    int lat;
    logic [7:0] b;
    bit ok;
    int gb;

    idle(3);
    check("reset_rx_byte", 32'(rx_byte), 32'h00);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_rx_frame_err", 32'(rx_frame_err), 32'd0);
    check("reset_rx_busy", 32'(rx_busy), 32'd0);
    rst = 1'b0;
    idle(300);
    check("idle_after_reset_busy", 32'(rx_busy), 32'd0);

    n0 = valid_cyc.size();
    send_frame(8'h42, 1'b1, -1, 0);
    idle(50);
    check("loopback_count", 32'(valid_cyc.size() - n0), 32'd1);
    if (valid_cyc.size() > n0) begin
      lat = valid_cyc[n0] - t_fall;
      check("loopback_latency_992pm1", 32'(lat >= 991 && lat <= 993), 32'd1);
    end

    n0 = valid_cyc.size();
    send_frame(8'h55, 1'b1, -1, 0);
    send_frame(8'hAA, 1'b1, -1, 0);
    idle(200);
    check("b2b_count", 32'(valid_cyc.size() - n0), 32'd2);
    if (valid_cyc.size() >= n0 + 2) begin
      lat = valid_cyc[n0+1] - valid_cyc[n0];
      check("b2b_spacing_1040pm1", 32'(lat >= 1039 && lat <= 1041), 32'd1);
    end

    busy_cnt = 0;
    rxd = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (rx_busy) busy_cnt++;
    end
    rxd = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (rx_busy) busy_cnt++;
    end
    check("glitch_busy_cycles", 32'(busy_cnt), 32'd54);
    check("glitch_back_idle", 32'(rx_busy), 32'd0);

    send_frame(8'hC3, 1'b1, 2, 53);
    idle(20);
    check("spike_rx_byte", 32'(rx_byte), 32'hC3);

    send_frame(8'h00, 1'b0, -1, 0);
    idle(2000);
    check("break_busy_held", 32'(rx_busy), 32'd1);
    check("break_rx_byte_unchanged", 32'(rx_byte), 32'hC3);
    rxd = 1'b1;
    idle(10);
    check("break_recovered_idle", 32'(rx_busy), 32'd0);
    send_frame(8'h41, 1'b1, -1, 0);
    idle(20);

    drive_bit(1'b0, BIT);
    drive_bit(1'b0, BIT);
    drive_bit(1'b1, BIT);
    drive_bit(1'b1, BIT);
    drive_bit(1'b1, BIT);
    drive_bit(1'b1, 50);
    rst = 1'b1;
    #1;
    check("midframe_rst_rx_byte", 32'(rx_byte), 32'h00);
    check("midframe_rst_rx_busy", 32'(rx_busy), 32'd0);
    check("midframe_rst_rx_valid", 32'(rx_valid), 32'd0);
    model_byte = 8'h00;
    rxd = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1200);
    check("midframe_rst_no_pending", 32'(exp_q.size()), 32'd0);
    send_frame(8'h7E, 1'b1, -1, 0);
    idle(20);
    check("after_rst_rx_byte", 32'(rx_byte), 32'h7E);

    for (int k = 0; k < 20; k++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(7) != 0);
      gb = ($urandom_range(1) == 1) ? int'($urandom_range(7)) : -1;
      send_frame(b, ok, gb, int'($urandom_range(BIT - 1)));
      if (!ok) begin
        idle(int'($urandom_range(300)));
        rxd = 1'b1;
        idle(4 + int'($urandom_range(20)));
      end else begin
        idle(int'($urandom_range(30)));
      end
    end
    idle(20);
    check("final_pending_frames", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
